// File: rtl/jk_excitation_driver.sv
// Programmable JK excitation sequencer: drives J/K so an attached JK bank walks a stored
// state sequence, and checks the bank's Q two edges after each step is issued.
module jk_excitation_driver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Load,
  input  logic [AW-1:0]    LoadAddr,
  input  logic [WIDTH-1:0] LoadData,
  input  logic [AW:0]      Length,
  input  logic             Loop,
  input  logic             Start,
  input  logic             Stop,
  input  logic [WIDTH-1:0] Q_obs,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Busy,
  output logic             Done,
  output logic             Mismatch,
  output logic [AW-1:0]    MismatchStep,
  output logic [WIDTH-1:0] MismatchQ
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    step_q, step_d;
  logic [AW-1:0]    chk_idx_q, chk_idx_d;
  logic             chk_v_q, chk_v_d;
  logic [AW:0]      len_q, len_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic [AW-1:0]    mis_step_q, mis_step_d;
  logic [WIDTH-1:0] mis_val_q, mis_val_d;

  logic             mem_we;
  logic [AW:0]      eff_len;
  logic [WIDTH-1:0] seq0;
  logic             check_fail;
  logic             has_next;
  logic [AW-1:0]    nxt;

  // Holding bits get J=K=0, so J=K=1 can never be produced.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] t);
    return {~c & t, c & ~t};
  endfunction

  assign mem_we     = Load && (state_q == StIdle);
  assign eff_len    = (Length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : Length;
  // A write to entry 0 on the Start edge must be seen by the first excitation.
  assign seq0       = (mem_we && (LoadAddr == '0)) ? LoadData : mem_q[0];
  assign check_fail = chk_v_q && (Q_obs != mem_q[chk_idx_q]);
  assign has_next   = ({1'b0, step_q} + (AW+1)'(1)) < len_q;
  assign nxt        = has_next ? step_q + AW'(1) : '0;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    loop_d     = loop_q;
    chk_v_d    = 1'b0;
    chk_idx_d  = step_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    mis_d      = mis_q;
    mis_step_d = mis_step_q;
    mis_val_d  = mis_val_q;

    case (state_q)
      StIdle: begin
        if (Start && (eff_len != '0)) begin
          state_d    = StRun;
          step_d     = '0;
          len_d      = eff_len;
          loop_d     = Loop;
          {j_d, k_d} = excite(Q_obs, seq0);
          mis_d      = 1'b0;
          mis_step_d = '0;
          mis_val_d  = '0;
        end
      end
      StRun, StDrain: begin
        if (check_fail) begin
          mis_d      = 1'b1;
          mis_step_d = chk_idx_q;
          mis_val_d  = Q_obs;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (Stop) begin
          state_d = StIdle;
        end else if (state_q == StDrain) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          // Step issued on the previous edge gets checked one edge from now.
          chk_v_d = 1'b1;
          if (has_next || loop_q) begin
            step_d     = nxt;
            {j_d, k_d} = excite(mem_q[step_q], mem_q[nxt]);
          end else begin
            state_d = StDrain;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q    <= StIdle;
      step_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      chk_v_q    <= 1'b0;
      chk_idx_q  <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      mis_step_q <= '0;
      mis_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      chk_v_q    <= chk_v_d;
      chk_idx_q  <= chk_idx_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      mis_step_q <= mis_step_d;
      mis_val_q  <= mis_val_d;
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[LoadAddr] <= LoadData;
    end
  end

  assign J            = j_q;
  assign K            = k_q;
  assign Busy         = (state_q != StIdle);
  assign Done         = done_q;
  assign Mismatch     = mis_q;
  assign MismatchStep = mis_step_q;
  assign MismatchQ    = mis_val_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: JK bank model with stuck-at faults, an edge-offset reference
// model compared every cycle, directed literal checks, then a randomized phase.
module tb_jk_excitation_driver;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       Load = 1'b0;
  logic [2:0] LoadAddr = '0;
  logic [3:0] LoadData = '0;
  logic [3:0] Length = '0;
  logic       Loop = 1'b0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic [3:0] Q_obs, J, K, MismatchQ;
  logic       Busy, Done, Mismatch;
  logic [2:0] MismatchStep;

  logic [3:0] bank_q = '0;
  logic [3:0] stuck = '0;
  logic       bank_zero = 1'b0;
  int         total = 0;
  int         bad = 0;
  bit         cmp_en = 1'b0;

  always #5 Clk = ~Clk;

  jk_excitation_driver #(.WIDTH(4), .DEPTH(8)) dut (
    .Clk(Clk), .Clr(Clr), .Load(Load), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .Length(Length), .Loop(Loop), .Start(Start), .Stop(Stop), .Q_obs(Q_obs),
    .J(J), .K(K), .Busy(Busy), .Done(Done), .Mismatch(Mismatch),
    .MismatchStep(MismatchStep), .MismatchQ(MismatchQ)
  );

  // Driven JK bank; stuck bits are forced to 0.
  assign Q_obs = bank_q;
  always @(posedge Clk) begin
    if (bank_zero) bank_q <= '0;
    else           bank_q <= ((J & ~bank_q) | (~K & bank_q)) & ~stuck;
  end

  // Reference model: behaviour expressed as a function of edges elapsed since Start.
  typedef struct packed {
    logic [7:0][3:0] mem;
    logic            active;
    logic            loop;
    logic [31:0]     r;
    logic [31:0]     len;
    logic [3:0]      j;
    logic [3:0]      k;
    logic [3:0]      mq;
    logic            busy;
    logic            done;
    logic            mis;
    logic [2:0]      mstep;
  } model_t;

  model_t ms;

  function automatic logic [7:0] excite_m(input logic [3:0] c, input logic [3:0] t);
    logic [3:0] j = '0;
    logic [3:0] k = '0;
    for (int i = 0; i < 4; i++) begin
      case ({c[i], t[i]})
        2'b01:   j[i] = 1'b1;
        2'b10:   k[i] = 1'b1;
        default: ;
      endcase
    end
    return {j, k};
  endfunction

  function automatic model_t model_next(input model_t m, input logic ld, input logic [2:0] la,
                                        input logic [3:0] ldat, input logic st,
                                        input logic [3:0] ln, input logic lp, input logic sp,
                                        input logic [3:0] q);
    model_t n = m;
    int     eff;
    int     s = 0;
    int     a, b;
    logic   fail = 1'b0;
    n.done = 1'b0;
    n.j = '0;
    n.k = '0;
    if (!n.active) begin
      if (ld) n.mem[la] = ldat;
      eff = (int'(ln) > 8) ? 8 : int'(ln);
      if (st && eff != 0) begin
        n.active = 1'b1;
        n.r = 0;
        n.len = 32'(eff);
        n.loop = lp;
        n.busy = 1'b1;
        n.mis = 1'b0;
        n.mstep = '0;
        n.mq = '0;
        {n.j, n.k} = excite_m(q, n.mem[0]);
      end
    end else begin
      n.r = n.r + 1;
      if (n.r >= 2 && (n.loop || (n.r - 2) < n.len)) begin
        s = int'((n.r - 2) % n.len);
        fail = (q !== n.mem[s]);
      end
      if (fail) begin
        n.mis = 1'b1;
        n.mstep = 3'(s);
        n.mq = q;
        n.done = 1'b1;
        n.active = 1'b0;
        n.busy = 1'b0;
      end else if (sp) begin
        n.active = 1'b0;
        n.busy = 1'b0;
      end else if (n.loop || n.r < n.len) begin
        a = int'((n.r - 1) % n.len);
        b = int'(n.r % n.len);
        {n.j, n.k} = excite_m(n.mem[a], n.mem[b]);
      end else if (n.r > n.len) begin
        n.done = 1'b1;
        n.active = 1'b0;
        n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge Clk or negedge Clr) begin
    if (!Clr) ms <= '0;
    else ms <= model_next(ms, Load, LoadAddr, LoadData, Start, Length, Loop, Stop, Q_obs);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("model_J", 32'(J), 32'(ms.j));
      check("model_K", 32'(K), 32'(ms.k));
      check("model_Busy", 32'(Busy), 32'(ms.busy));
      check("model_Done", 32'(Done), 32'(ms.done));
      check("model_Mismatch", 32'(Mismatch), 32'(ms.mis));
      check("model_MismatchStep", 32'(MismatchStep), 32'(ms.mstep));
      check("model_MismatchQ", 32'(MismatchQ), 32'(ms.mq));
    end
  end

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic load(input logic [2:0] a, input logic [3:0] d);
    Load = 1'b1;
    LoadAddr = a;
    LoadData = d;
    tick();
    Load = 1'b0;
  endtask

  task automatic zero_bank;
    bank_zero = 1'b1;
    tick();
    bank_zero = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] len, input logic lp);
    Start = 1'b1;
    Length = len;
    Loop = lp;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    int  busy_cnt;
    bit  saw_done;
    tick();
    cmp_en = 1'b1;
    tick();
    Clr = 1'b1;

    // Asynchronous clear in the middle of a run.
    load(3'd0, 4'b0011);
    zero_bank();
    start_run(4'd1, 1'b0);
    check("rst_pre_J", 32'(J), 32'h3);
    #2 Clr = 1'b0;
    #1;
    check("rst_J", 32'(J), 32'h0);
    check("rst_K", 32'(K), 32'h0);
    check("rst_Busy", 32'(Busy), 32'h0);
    check("rst_Done", 32'(Done), 32'h0);
    check("rst_Mismatch", 32'(Mismatch), 32'h0);
    @(negedge Clk);
    Clr = 1'b1;
    zero_bank();
    start_run(4'd1, 1'b0);
    check("rst_cleared_mem_J", 32'(J), 32'h0);
    check("rst_cleared_mem_K", 32'(K), 32'h0);
    check("rst_run_Busy", 32'(Busy), 32'h1);
    tick();
    tick();
    check("len1_Done", 32'(Done), 32'h1);
    tick();

    // Nominal three-step run.
    load(3'd0, 4'b0001);
    load(3'd1, 4'b0010);
    load(3'd2, 4'b0011);
    zero_bank();
    start_run(4'd3, 1'b0);
    check("nom_e0_J", 32'(J), 32'h1);
    check("nom_e0_K", 32'(K), 32'h0);
    tick();
    check("nom_e1_J", 32'(J), 32'h2);
    check("nom_e1_K", 32'(K), 32'h1);
    tick();
    check("nom_e2_J", 32'(J), 32'h1);
    check("nom_e2_K", 32'(K), 32'h0);
    tick();
    check("nom_e3_JK", 32'({J, K}), 32'h0);
    check("nom_e3_Busy", 32'(Busy), 32'h1);
    tick();
    check("nom_e4_Done", 32'(Done), 32'h1);
    check("nom_e4_Busy", 32'(Busy), 32'h0);
    check("nom_e4_Mismatch", 32'(Mismatch), 32'h0);
    tick();

    // Bit 1 stuck at 0.
    stuck = 4'b0010;
    zero_bank();
    start_run(4'd3, 1'b0);
    tick();
    tick();
    tick();
    check("flt_Mismatch", 32'(Mismatch), 32'h1);
    check("flt_Step", 32'(MismatchStep), 32'h1);
    check("flt_Q", 32'(MismatchQ), 32'h0);
    check("flt_JK", 32'({J, K}), 32'h0);
    check("flt_Done", 32'(Done), 32'h1);
    check("flt_Busy", 32'(Busy), 32'h0);
    tick();

    // Stop on the same edge as the failing check.
    zero_bank();
    start_run(4'd3, 1'b0);
    tick();
    tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("stopflt_Mismatch", 32'(Mismatch), 32'h1);
    check("stopflt_Done", 32'(Done), 32'h1);
    stuck = '0;
    tick();

    // Looping two-step run, then Stop.
    load(3'd0, 4'b0101);
    load(3'd1, 4'b1010);
    zero_bank();
    start_run(4'd2, 1'b1);
    check("loop_e0_JK", 32'({J, K}), 32'h50);
    tick();
    check("loop_e1_JK", 32'({J, K}), 32'hA5);
    tick();
    check("loop_e2_JK", 32'({J, K}), 32'h5A);
    tick();
    check("loop_e3_JK", 32'({J, K}), 32'hA5);
    repeat (5) tick();
    check("loop_Busy", 32'(Busy), 32'h1);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    Loop = 1'b0;
    check("stop_JK", 32'({J, K}), 32'h0);
    check("stop_Busy", 32'(Busy), 32'h0);
    check("stop_Done", 32'(Done), 32'h0);
    check("stop_Mismatch", 32'(Mismatch), 32'h0);
    tick();

    // Zero length is ignored.
    start_run(4'd0, 1'b0);
    check("len0_Busy", 32'(Busy), 32'h0);

    // Length 12 clamps to 8 steps; a Load while busy is dropped.
    for (int i = 0; i < 8; i++) load(3'(i), 4'(i * 5 + 6));
    zero_bank();
    start_run(4'd12, 1'b0);
    busy_cnt = Busy ? 1 : 0;
    saw_done = 1'b0;
    for (int i = 0; i < 30 && !saw_done; i++) begin
      Load = (i == 0);
      LoadAddr = 3'd0;
      LoadData = 4'hF;
      tick();
      Load = 1'b0;
      if (Busy) busy_cnt++;
      if (Done) saw_done = 1'b1;
    end
    check("len12_done_seen", 32'(saw_done), 32'h1);
    check("len12_busy_cycles", 32'(busy_cnt), 32'd9);
    tick();
    zero_bank();
    start_run(4'd1, 1'b0);
    check("busy_load_ignored_J", 32'(J), 32'h6);
    repeat (3) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      Load = ($urandom_range(0, 3) == 0);
      LoadAddr = 3'($urandom);
      LoadData = 4'($urandom);
      Start = ($urandom_range(0, 5) == 0);
      Length = 4'($urandom);
      Loop = ($urandom_range(0, 3) == 0);
      Stop = ($urandom_range(0, 24) == 0);
      bank_zero = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 99) == 0) stuck = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
      if ($urandom_range(0, 399) == 0) begin
        Clr = 1'b0;
        tick();
        Clr = 1'b1;
      end else begin
        tick();
      end
    end
    Load = 1'b0;
    Start = 1'b0;
    Stop = 1'b0;
    bank_zero = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
